// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter
//
// Merges the core's instruction-fetch miss port, data-read miss port and
// posted data-write stream onto a single request/acknowledge memory bus.
// Writes are posted into a small FIFO write buffer. Reads are returned to the
// core as one-cycle fill pulses. The core is stalled while it tries to write
// into a full buffer.
//
// Arbitration in IDLE: buffered write > data read > instruction fetch.
// A data read is only issued once the write buffer has drained. This keeps
// read-after-write ordering without any address comparison.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN):
//   Enables a bus watchdog. A transaction that sees no ack for TIMEOUT BUS
//   cycles is completed as if acked with read data 0. When that happens,
//   o_bus_err is set and stays set until rst. Without the macro, BUS waits
//   indefinitely and o_bus_err is tied low.
//
// Parameters:
//   WBUF_DEPTH  write-buffer entries (power of 2, >= 2)
//   TIMEOUT     watchdog limit in BUS cycles (watchdog build only)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_iaddr, i_iread_en           fetch miss address / request (held to fill)
//   o_inst, o_iread_vd            fetch fill data / fill pulse
//   i_memaddr, i_read_en          data address / read miss request
//   o_read_data, o_read_vd        data fill / fill pulse
//   i_write_en, i_write_data      data write strobe / word
//   o_exstall                     core stall (write while buffer full)
//   o_bus_req, o_bus_we           external request / write qualifier
//   o_bus_addr, o_bus_wdata       external address / write data
//   i_bus_ack, i_bus_rdata        external completion / read data
//   o_bus_err                     sticky watchdog timeout flag
//------------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_iaddr,
    input  logic        i_iread_en,
    output logic [31:0] o_inst,
    output logic        o_iread_vd,
    input  logic [31:0] i_memaddr,
    input  logic        i_read_en,
    output logic [31:0] o_read_data,
    output logic        o_read_vd,
    input  logic        i_write_en,
    input  logic [31:0] i_write_data,
    output logic        o_exstall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_err
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(WBUF_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SRC_WR = 2'd0;
    localparam logic [1:0] SRC_DR = 2'd1;
    localparam logic [1:0] SRC_IF = 2'd2;

    logic [31:0]      wbuf_addr [WBUF_DEPTH];
    logic [31:0]      wbuf_data [WBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   wbuf_count;
    logic             wbuf_full;
    logic             wbuf_empty;
    logic             push;
    logic             pop;

    logic [1:0]       state;
    logic [1:0]       src;
    logic             bus_done;
    logic             tmo_hit;
    logic [31:0]      fill_data;

    assign wbuf_full  = (wbuf_count == FULL_CNT);
    assign wbuf_empty = (wbuf_count == '0);
    assign push       = i_write_en && !wbuf_full;
    assign o_exstall  = i_write_en && wbuf_full;

    // A transaction finishes on ack or on watchdog expiry. A write finishing
    // frees its buffer slot at that same edge, so a stalled write is taken
    // in the very next cycle.
    assign bus_done = (state == ST_BUS) && (i_bus_ack || tmo_hit);
    assign pop      = bus_done && (src == SRC_WR);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             bus_err_q;

    // The counter holds the number of ack-less BUS cycles already elapsed.
    // It is cleared outside BUS, so it is always zero on entry.
    assign tmo_hit   = (state == ST_BUS) && !i_bus_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign fill_data = i_bus_ack ? i_bus_rdata : 32'h0;
    assign o_bus_err = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state != ST_BUS) begin
                tmo_cnt <= '0;
            end else if (!i_bus_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign fill_data = i_bus_rdata;
    // TIMEOUT has no effect in this build. The comparison is false for every
    // legal value, so the flag is tied low, and the parameter list stays the
    // same in both builds.
    assign o_bus_err = (TIMEOUT < 0);
`endif

    // Write-buffer storage. It has no reset because only entries between the
    // pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_addr[wr_ptr] <= i_memaddr;
            wbuf_data[wr_ptr] <= i_write_data;
        end
    end

    // Buffer pointers and occupancy. Because the depth is a power of two,
    // the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wbuf_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   wbuf_count <= wbuf_count + 1'b1;
                2'b01:   wbuf_count <= wbuf_count - 1'b1;
                default: wbuf_count <= wbuf_count;
            endcase
        end
    end

    // Arbitration and bus sequencing. Bus outputs are registered on grant and
    // held through BUS. RESP is a single cycle that carries the fill pulse.
    // That cycle gives the core's cache an edge to install the line before
    // IDLE samples the requests again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            src         <= SRC_WR;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_read_vd   <= 1'b0;
            o_iread_vd  <= 1'b0;
            o_read_data <= '0;
            o_inst      <= '0;
        end else begin
            o_read_vd  <= 1'b0;
            o_iread_vd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!wbuf_empty) begin
                        src         <= SRC_WR;
                        state       <= ST_BUS;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= 1'b1;
                        o_bus_addr  <= wbuf_addr[rd_ptr];
                        o_bus_wdata <= wbuf_data[rd_ptr];
                    end else if (i_read_en) begin
                        src         <= SRC_DR;
                        state       <= ST_BUS;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= i_memaddr;
                        o_bus_wdata <= '0;
                    end else if (i_iread_en) begin
                        src         <= SRC_IF;
                        state       <= ST_BUS;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= i_iaddr;
                        o_bus_wdata <= '0;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        o_bus_req <= 1'b0;
                        if (src == SRC_WR) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_RESP;
                            if (src == SRC_DR) begin
                                o_read_data <= fill_data;
                                o_read_vd   <= 1'b1;
                            end else begin
                                o_inst     <= fill_data;
                                o_iread_vd <= 1'b1;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
